// File: rtl/ex_alu_issue_if.sv
// ID/EX issue channel and EX/MEM result channel of the execute-stage ALU initiator.
// slave is the execute stage's view; master is the surrounding pipeline's view.
interface ex_alu_issue_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic            id_ready;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic            id_funct7b5;
  logic [XLEN-1:0] id_rs1_val;
  logic [XLEN-1:0] id_rs2_val;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rd;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_result;
  logic [4:0]      ex_rd;
  logic            ex_br_taken;
  logic            ex_illegal;

  modport slave (
    input  id_valid, id_opcode, id_funct3, id_funct7b5,
    input  id_rs1_val, id_rs2_val, id_imm, id_rd,
    output id_ready,
    output ex_valid, ex_result, ex_rd, ex_br_taken, ex_illegal,
    input  ex_ready
  );

  modport master (
    output id_valid, id_opcode, id_funct3, id_funct7b5,
    output id_rs1_val, id_rs2_val, id_imm, id_rd,
    input  id_ready,
    input  ex_valid, ex_result, ex_rd, ex_br_taken, ex_illegal,
    output ex_ready
  );
endinterface

// File: rtl/ex_alu_issue.sv
// Execute-stage initiator: decodes an ID/EX instruction, drives an external
// combinational ALU and captures its result into a single-entry EX/MEM register.
module ex_alu_issue #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ex_alu_issue_if.slave    bus,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [2:0]       alu_op,
  input  logic [XLEN-1:0]  alu_y,
  input  logic             alu_zero,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_ILL = 3'b111;

  logic            op_legal;
  logic            use_imm;
  logic            is_branch;
  logic [2:0]      op_dec;
  logic            br_taken_d;
  logic [4:0]      rd_d;
  logic            accept;

  logic            ex_valid_q;
  logic [XLEN-1:0] ex_result_q;
  logic [4:0]      ex_rd_q;
  logic            ex_br_taken_q;
  logic            ex_illegal_q;
  logic [CNT_W-1:0] stall_q;

  // Decode: anything not explicitly recognised stays illegal.
  always_comb begin
    op_legal  = 1'b0;
    use_imm   = 1'b0;
    is_branch = 1'b0;
    op_dec    = ALU_ILL;
    case (bus.id_opcode)
      OPC_R: begin
        case (bus.id_funct3)
          3'b000: begin
            op_legal = 1'b1;
            op_dec   = bus.id_funct7b5 ? ALU_SUB : ALU_ADD;
          end
          3'b111: begin
            op_legal = ~bus.id_funct7b5;
            op_dec   = ALU_AND;
          end
          3'b110: begin
            op_legal = ~bus.id_funct7b5;
            op_dec   = ALU_OR;
          end
          default: op_legal = 1'b0;
        endcase
      end
      OPC_I: begin
        use_imm = 1'b1;
        case (bus.id_funct3)
          3'b000: begin
            op_legal = 1'b1;
            op_dec   = ALU_ADD;
          end
          3'b111: begin
            op_legal = 1'b1;
            op_dec   = ALU_AND;
          end
          3'b110: begin
            op_legal = 1'b1;
            op_dec   = ALU_OR;
          end
          default: op_legal = 1'b0;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        use_imm  = 1'b1;
        op_legal = 1'b1;
        op_dec   = ALU_ADD;
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        op_dec    = ALU_SUB;
        op_legal  = (bus.id_funct3 == 3'b000) || (bus.id_funct3 == 3'b001);
      end
      default: op_legal = 1'b0;
    endcase
  end

  assign alu_op = op_legal ? op_dec : ALU_ILL;
  assign alu_a  = bus.id_rs1_val;
  assign alu_b  = use_imm ? bus.id_imm : bus.id_rs2_val;

  // Only BEQ/BNE survive decode as branches, so funct3[0] picks the polarity.
  assign br_taken_d = is_branch & op_legal &
                      (bus.id_funct3[0] ? ~alu_zero : alu_zero);
  assign rd_d       = (is_branch | ~op_legal) ? 5'd0 : bus.id_rd;

  assign bus.id_ready = ~ex_valid_q | bus.ex_ready;
  assign accept       = bus.id_valid & bus.id_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_result_q   <= '0;
      ex_rd_q       <= 5'd0;
      ex_br_taken_q <= 1'b0;
      ex_illegal_q  <= 1'b0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (accept) begin
      ex_valid_q    <= 1'b1;
      ex_result_q   <= alu_y;
      ex_rd_q       <= rd_d;
      ex_br_taken_q <= br_taken_d;
      ex_illegal_q  <= ~op_legal;
    end else if (ex_valid_q && bus.ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  // Backpressure counter survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (ex_valid_q && !bus.ex_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_result   = ex_result_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.ex_br_taken = ex_br_taken_q;
  assign bus.ex_illegal  = ex_illegal_q;
  assign stall_cnt       = stall_q;

endmodule

// File: tb/tb_ex_alu_issue.sv
// Scoreboard bench for ex_alu_issue with a behavioural ALU stand-in.
// CNT_W is shrunk to 3 so stall-counter saturation is reachable quickly.
module tb_ex_alu_issue;
  localparam int XLEN  = 32;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        br;
    logic        ill;
    logic [2:0]  op;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [XLEN-1:0]  alu_a, alu_b, alu_y;
  logic [2:0]       alu_op;
  logic             alu_zero;
  logic [CNT_W-1:0] stall_cnt;
  logic             rnd_rdy = 1'b0;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  ex_alu_issue_if #(.XLEN(XLEN)) bus ();

  ex_alu_issue #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .alu_zero  (alu_zero),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      3'b000:  alu_y = alu_a + alu_b;
      3'b001:  alu_y = alu_a - alu_b;
      3'b010:  alu_y = alu_a & alu_b;
      3'b011:  alu_y = alu_a | alu_b;
      default: alu_y = 32'hDEADBEEF;
    endcase
  end
  assign alu_zero = (alu_y == '0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [4:0] rd);
    exp_t e;
    logic ok;
    e = '0;
    e.rd = rd;
    ok = 1'b1;
    case (opc)
      7'b0110011: begin
        if (f3 == 3'b000 && !f7)     begin e.res = a + b; e.op = 3'b000; end
        else if (f3 == 3'b000 && f7) begin e.res = a - b; e.op = 3'b001; end
        else if (f3 == 3'b111 && !f7) begin e.res = a & b; e.op = 3'b010; end
        else if (f3 == 3'b110 && !f7) begin e.res = a | b; e.op = 3'b011; end
        else ok = 1'b0;
      end
      7'b0010011: begin
        if (f3 == 3'b000)      begin e.res = a + imm; e.op = 3'b000; end
        else if (f3 == 3'b111) begin e.res = a & imm; e.op = 3'b010; end
        else if (f3 == 3'b110) begin e.res = a | imm; e.op = 3'b011; end
        else ok = 1'b0;
      end
      7'b0000011, 7'b0100011: begin
        e.res = a + imm;
        e.op  = 3'b000;
      end
      7'b1100011: begin
        e.res = a - b;
        e.op  = 3'b001;
        e.rd  = 5'd0;
        if (f3 == 3'b000)      e.br = (a == b);
        else if (f3 == 3'b001) e.br = (a != b);
        else ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.res = 32'hDEADBEEF;
      e.op  = 3'b111;
      e.rd  = 5'd0;
      e.br  = 1'b0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Retire first, then drop whatever a flush kills, then record a new acceptance.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.ex_valid && bus.ex_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_retire", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_result",   bus.ex_result,           e.res);
          check("sb_rd",       {27'd0, bus.ex_rd},      {27'd0, e.rd});
          check("sb_br_taken", {31'd0, bus.ex_br_taken}, {31'd0, e.br});
          check("sb_illegal",  {31'd0, bus.ex_illegal},  {31'd0, e.ill});
        end
      end
      if (flush) sb.delete();
      if (bus.id_valid && bus.id_ready && !flush)
        sb.push_back(model(bus.id_opcode, bus.id_funct3, bus.id_funct7b5,
                           bus.id_rs1_val, bus.id_rs2_val, bus.id_imm, bus.id_rd));
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      bus.ex_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] rd);
    bus.id_valid    = 1'b1;
    bus.id_opcode   = opc;
    bus.id_funct3   = f3;
    bus.id_funct7b5 = f7;
    bus.id_rs1_val  = a;
    bus.id_rs2_val  = b;
    bus.id_imm      = imm;
    bus.id_rd       = rd;
  endtask

  // Present one instruction, check the decoded alu_op, wait until it is accepted.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] rd);
    exp_t e;
    logic acc;
    int   n;
    present(opc, f3, f7, a, b, imm, rd);
    e = model(opc, f3, f7, a, b, imm, rd);
    #1;
    check("alu_op", {29'd0, alu_op}, {29'd0, e.op});
    n = 0;
    do begin
      @(negedge clk);
      acc = bus.id_ready && !flush;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) check("issue_timeout", 32'd0, 32'd1);
    bus.id_valid = 1'b0;
  endtask

  task automatic pick(input int k, output logic [6:0] opc, output logic [2:0] f3, output logic f7);
    f7 = 1'b0;
    case (k)
      0:  begin opc = 7'b0110011; f3 = 3'b000; end
      1:  begin opc = 7'b0110011; f3 = 3'b000; f7 = 1'b1; end
      2:  begin opc = 7'b0110011; f3 = 3'b111; end
      3:  begin opc = 7'b0110011; f3 = 3'b110; end
      4:  begin opc = 7'b0110011; f3 = 3'b110; f7 = 1'b1; end
      5:  begin opc = 7'b0010011; f3 = 3'b000; f7 = 1'($urandom_range(0, 1)); end
      6:  begin opc = 7'b0010011; f3 = 3'b111; end
      7:  begin opc = 7'b0010011; f3 = 3'b110; end
      8:  begin opc = 7'b0010011; f3 = 3'b001; end
      9:  begin opc = 7'b0000011; f3 = 3'b010; end
      10: begin opc = 7'b0100011; f3 = 3'b010; end
      11: begin opc = 7'b1100011; f3 = 3'b000; end
      12: begin opc = 7'b1100011; f3 = 3'b001; end
      13: begin opc = 7'b1100011; f3 = 3'b100; end
      default: begin opc = 7'b1101111; f3 = 3'b000; end
    endcase
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.ex_ready = 1'b0;
    present(7'd0, 3'd0, 1'b0, '0, '0, '0, 5'd0);
    bus.id_valid = 1'b0;
    repeat (2) tick();
    check("rst_ex_valid",  {31'd0, bus.ex_valid},    32'd0);
    check("rst_ex_result", bus.ex_result,             32'd0);
    check("rst_ex_rd",     {27'd0, bus.ex_rd},       32'd0);
    check("rst_br_taken",  {31'd0, bus.ex_br_taken}, 32'd0);
    check("rst_illegal",   {31'd0, bus.ex_illegal},  32'd0);
    check("rst_stall_cnt", {29'd0, stall_cnt},       32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_id_ready",  {31'd0, bus.id_ready},    32'd1);

    bus.ex_ready = 1'b1;
    issue(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3);
    check("add_valid",  {31'd0, bus.ex_valid}, 32'd1);
    check("add_result", bus.ex_result,         32'd12);
    check("add_rd",     {27'd0, bus.ex_rd},    32'd3);
    issue(7'b0110011, 3'b000, 1'b1, 32'd0, 32'd1, 32'd0, 5'd4);
    check("sub_result", bus.ex_result, 32'hFFFFFFFF);
    issue(7'b1100011, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0, 5'd5);
    check("beq_taken", {31'd0, bus.ex_br_taken}, 32'd1);
    check("beq_rd",    {27'd0, bus.ex_rd},       32'd0);
    issue(7'b1100011, 3'b001, 1'b0, 32'd9, 32'd9, 32'd0, 5'd5);
    check("bne_taken", {31'd0, bus.ex_br_taken}, 32'd0);
    issue(7'b0110011, 3'b001, 1'b0, 32'd1, 32'd2, 32'd0, 5'd6);
    check("ill_result",  bus.ex_result,            32'hDEADBEEF);
    check("ill_illegal", {31'd0, bus.ex_illegal},  32'd1);
    check("ill_rd",      {27'd0, bus.ex_rd},       32'd0);
    issue(7'b0010011, 3'b111, 1'b0, 32'hFF00FF00, 32'd0, 32'h0FF00FF0, 5'd7);
    issue(7'b0100011, 3'b010, 1'b0, 32'h1000, 32'd3, 32'hFFFFFFFC, 5'd8);
    issue(7'b0110011, 3'b110, 1'b1, 32'd1, 32'd2, 32'd0, 5'd9);
    issue(7'b0110011, 3'b111, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 5'd1);
    issue(7'b0010011, 3'b000, 1'b0, 32'hFFFFFFFF, 32'd0, 32'd1, 5'd2);

    // Backpressure: held entry must stay frozen while the next one waits.
    issue(7'b0110011, 3'b000, 1'b0, 32'd100, 32'd23, 32'd0, 5'd4);
    bus.ex_ready = 1'b0;
    present(7'b0110011, 3'b000, 1'b1, 32'd50, 32'd8, 32'd0, 5'd6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_id_ready", {31'd0, bus.id_ready}, 32'd0);
      check("hold_valid",    {31'd0, bus.ex_valid}, 32'd1);
      check("hold_result",   bus.ex_result,         32'd123);
      check("hold_rd",       {27'd0, bus.ex_rd},    32'd4);
      tick();
    end
    check("hold_stall_cnt", {29'd0, stall_cnt}, 32'd4);
    bus.ex_ready = 1'b1;
    @(negedge clk);
    check("release_id_ready", {31'd0, bus.id_ready}, 32'd1);
    tick();
    check("b2b_valid",  {31'd0, bus.ex_valid}, 32'd1);
    check("b2b_result", bus.ex_result,         32'd42);
    check("b2b_stall",  {29'd0, stall_cnt},    32'd4);

    flush = 1'b1;
    present(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 5'd7);
    tick();
    check("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("flush_stall", {29'd0, stall_cnt},    32'd4);
    tick();
    check("flush_valid2", {31'd0, bus.ex_valid}, 32'd0);
    flush = 1'b0;
    bus.id_valid = 1'b0;

    issue(7'b0110011, 3'b110, 1'b0, 32'hF0, 32'h0F, 32'd0, 5'd8);
    bus.ex_ready = 1'b0;
    flush = 1'b1;
    tick();
    check("flush_hold_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("flush_hold_stall", {29'd0, stall_cnt},    32'd5);
    flush = 1'b0;

    bus.ex_ready = 1'b1;
    issue(7'b0010011, 3'b110, 1'b0, 32'd1, 32'd0, 32'd2, 5'd9);
    bus.ex_ready = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("async_rst_stall", {29'd0, stall_cnt},    32'd0);
    check("async_rst_ready", {31'd0, bus.id_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    bus.ex_ready = 1'b1;
    tick();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] a, b;
      pick(int'($urandom_range(0, 14)), opc, f3, f7);
      a = $urandom();
      b = ($urandom_range(0, 1) != 0) ? a : $urandom();
      issue(opc, f3, f7, a, b, $urandom(), 5'($urandom_range(0, 31)));
    end
    rnd_rdy = 1'b0;
    tick();
    bus.ex_ready = 1'b1;
    repeat (3) tick();
    check("sb_drained", sb.size(), 32'd0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    issue(7'b0110011, 3'b000, 1'b0, 32'd2, 32'd3, 32'd0, 5'd10);
    bus.ex_ready = 1'b0;
    repeat (10) tick();
    check("sat_stall",    {29'd0, stall_cnt},    32'd7);
    check("sat_valid",    {31'd0, bus.ex_valid}, 32'd1);
    check("sat_id_ready", {31'd0, bus.id_ready}, 32'd0);
    bus.ex_ready = 1'b1;
    tick();
    check("sat_retired", {31'd0, bus.ex_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
